n_bit_full_adder: RTL and testbench

N_BIT_FULL_ADDER -- requirements
Module: n_bit_full_adder

---
 rtl/n_bit_full_adder.sv | 53 +++++
 tb/tb_n_bit_full_adder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/n_bit_full_adder.sv
// Parameterised ripple-carry adder with combinational sum/carry/overflow
// and an enabled, asynchronously reset registered copy of those results.
module n_bit_full_adder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic [N-1:0] s_q,
  output logic         cout_q,
  output logic         ovf_q,
  output logic         valid_q
);

  logic [N:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_cell
      logic p;
      assign p        = a[i] ^ b[i];
      assign s[i]     = p ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
    end
  endgenerate

  // For N = 1, c[N-1] is cin, so this also covers the single-bit case.
  assign cout = c[N];
  assign ovf  = c[N] ^ c[N-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      s_q     <= s;
      cout_q  <= cout;
      ovf_q   <= ovf;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_n_bit_full_adder.sv
// Self-checking bench for n_bit_full_adder: directed vectors, registered
// path, hold, async reset and an exhaustive 4-bit sweep via a scoreboard.
module tb_n_bit_full_adder;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;
  logic [N-1:0] s_q;
  logic         cout_q;
  logic         ovf_q;
  logic         valid_q;

  int compared;
  int mismatched;

  // Expected {ovf, cout, s} of each captured result, oldest first.
  logic [N+1:0] sbq[$];

  n_bit_full_adder #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .s       (s),
    .cout    (cout),
    .ovf     (ovf),
    .s_q     (s_q),
    .cout_q  (cout_q),
    .ovf_q   (ovf_q),
    .valid_q (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: N+1-bit zero-extended add; overflow when equal-signed
  // operands produce a sum of the other sign.
  function automatic logic [N+1:0] model(input logic [N-1:0] ma,
                                         input logic [N-1:0] mb,
                                         input logic         mc);
    logic [N:0] sum;
    logic       v;
    sum = {1'b0, ma} + {1'b0, mb} + {{N{1'b0}}, mc};
    v   = (ma[N-1] == mb[N-1]) && (sum[N-1] != ma[N-1]);
    return {v, sum};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] ta, input logic [N-1:0] tb,
                               input logic tc, input logic ten);
    a   = ta;
    b   = tb;
    cin = tc;
    en  = ten;
    #1;
    if (ten) sbq.push_back(model(ta, tb, tc));
  endtask

  task automatic checkComb(input string tag, input logic [N+1:0] exp);
    checkOutput({tag, "_s"},    32'(s),    32'(exp[N-1:0]));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(exp[N]));
    checkOutput({tag, "_ovf"},  32'(ovf),  32'(exp[N+1]));
  endtask

  task automatic checkRegistered(input string tag);
    logic [N+1:0] exp;
    if (sbq.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sbq.pop_front();
      checkOutput({tag, "_s_q"},    32'(s_q),    32'(exp[N-1:0]));
      checkOutput({tag, "_cout_q"}, 32'(cout_q), 32'(exp[N]));
      checkOutput({tag, "_ovf_q"},  32'(ovf_q),  32'(exp[N+1]));
      checkOutput({tag, "_valid_q"}, 32'(valid_q), 32'd1);
    end
  endtask

  typedef struct {
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic         vc;
    logic [N+1:0] vexp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    compared   = 0;
    mismatched = 0;
    vecs[0] = '{4'b1010, 4'b0101, 1'b0, {1'b0, 1'b0, 4'b1111}};
    vecs[1] = '{4'b1111, 4'b0001, 1'b0, {1'b0, 1'b1, 4'b0000}};
    vecs[2] = '{4'b0001, 4'b0001, 1'b0, {1'b0, 1'b0, 4'b0010}};
    vecs[3] = '{4'b1001, 4'b0110, 1'b1, {1'b0, 1'b1, 4'b0000}};
    vecs[4] = '{4'b0011, 4'b1100, 1'b1, {1'b0, 1'b1, 4'b0000}};
    vecs[5] = '{4'b0111, 4'b0001, 1'b0, {1'b1, 1'b0, 4'b1000}};
    vecs[6] = '{4'b1000, 4'b1000, 1'b0, {1'b1, 1'b1, 4'b0000}};

    rst_n = 1'b0;
    en    = 1'b1;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    // Reset held across an edge with en high: registers stay clear.
    @(posedge clk);
    #1;
    checkOutput("rst_s_q",     32'(s_q),     32'd0);
    checkOutput("rst_cout_q",  32'(cout_q),  32'd0);
    checkOutput("rst_ovf_q",   32'(ovf_q),   32'd0);
    checkOutput("rst_valid_q", 32'(valid_q), 32'd0);

    // Directed vectors: combinational outputs checked against fixed values.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vc, 1'b0);
      checkComb($sformatf("vec%0d", i), vecs[i].vexp);
    end

    // Release reset away from the edge, then one capture.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1010, 4'b0101, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkRegistered("cap1");

    // Hold: en low with new inputs leaves the captured value in place.
    @(negedge clk);
    applyStimulus(4'b0111, 4'b0001, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("hold_s_q",     32'(s_q),     32'b1111);
    checkOutput("hold_cout_q",  32'(cout_q),  32'd0);
    checkOutput("hold_ovf_q",   32'(ovf_q),   32'd0);
    checkOutput("hold_valid_q", 32'(valid_q), 32'd1);

    // Async reset between edges; combinational path must be unaffected.
    @(negedge clk);
    applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkRegistered("pre_arst");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_s_q",     32'(s_q),     32'd0);
    checkOutput("arst_cout_q",  32'(cout_q),  32'd0);
    checkOutput("arst_ovf_q",   32'(ovf_q),   32'd0);
    checkOutput("arst_valid_q", 32'(valid_q), 32'd0);
    checkComb("arst_comb", model(4'b1111, 4'b0000, 1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep: combinational check plus scoreboarded capture.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          applyStimulus(4'(ia), 4'(ib), 1'(ic), 1'b1);
          checkComb($sformatf("sw_%0h_%0h_%0d", ia, ib, ic),
                    model(4'(ia), 4'(ib), 1'(ic)));
          @(posedge clk);
          #1;
          checkRegistered($sformatf("swq_%0h_%0h_%0d", ia, ib, ic));
        end
      end
    end

    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
